// File: rtl/noc_pkg.sv
// Shared types and helpers for the five-port wormhole router: flit formats,
// port indices, output FSM states and the XY / round-robin index helpers.
package noc_pkg;

  localparam int NUM_PORTS     = 5;
  localparam int NOC_COORD_W   = 4;
  localparam int NOC_PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2
  } flit_type_t;

  typedef struct packed {
    flit_type_t                 flit_type;
    logic [NOC_PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef struct packed {
    logic [NOC_COORD_W-1:0] y;
    logic [NOC_COORD_W-1:0] x;
  } coord_t;

  // Occupies the low bits of a HEADER payload; upper payload bits are free.
  typedef struct packed {
    logic [7:0] tail_length;
    coord_t     dst_addr;
  } flit_hdr_t;

  typedef logic [2:0] port_t;

  localparam port_t NORTH = 3'd0;
  localparam port_t SOUTH = 3'd1;
  localparam port_t EAST  = 3'd2;
  localparam port_t WEST  = 3'd3;
  localparam port_t LOCAL = 3'd4;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  // Dimension-ordered routing: resolve x first, then y, else eject locally.
  function automatic port_t xy_route(input int unsigned dx, input int unsigned dy,
                                     input int unsigned mx, input int unsigned my);
    if (dx > mx) return EAST;
    if (dx < mx) return WEST;
    if (dy > my) return SOUTH;
    if (dy < my) return NORTH;
    return LOCAL;
  endfunction

  function automatic port_t rr_idx(input port_t last, input int k);
    return port_t'((int'(last) + k) % NUM_PORTS);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two so the
// pointers wrap naturally. Head entry is presented combinationally on data_o.
module noc_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty_o masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/noc_router.sv
// Five-port XY wormhole router with per-input FIFOs and per-output round-robin
// lock FSMs. Define NOC_ROUTER_STATS_EN to add per-output flit counters.
module noc_router
  import noc_pkg::*;
#(
  parameter int unsigned X_COORD    = 0,
  parameter int unsigned Y_COORD    = 0,
  parameter int          COORD_W    = 4,
  parameter int          PAYLOAD_W  = 32,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  flit_t                in_flit    [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] in_enable,
  output logic [NUM_PORTS-1:0] in_ack,
  output flit_t                out_flit   [NUM_PORTS],
  output logic [NUM_PORTS-1:0] out_enable,
  input  logic [NUM_PORTS-1:0] out_ack,
`ifdef NOC_ROUTER_STATS_EN
  output logic [31:0]          flit_count [NUM_PORTS],
`endif
  output out_state_e           dbg_out_state [NUM_PORTS]
);

  if (PAYLOAD_W != NOC_PAYLOAD_W || PAYLOAD_W < 2*COORD_W + 8) begin : g_bad_cfg
    $error("noc_router: PAYLOAD_W must match noc_pkg and hold a header");
  end

  // Handshake: a flit moves on a rising edge where enable && ack. in_ack is
  // a registered-state function (not full, out of reset); out_enable never
  // looks at out_ack.

  flit_t                head_flit [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic                 ready_q, ready_d;
  logic [NUM_PORTS-1:0] route_valid_q, route_valid_d;
  port_t                route_q [NUM_PORTS];
  port_t                route_d [NUM_PORTS];

  port_t                hdr_route [NUM_PORTS];
  port_t                req_dest  [NUM_PORTS];
  logic [NUM_PORTS-1:0] is_hdr, req_valid, drop;

  out_state_e           state_q [NUM_PORTS];
  out_state_e           state_d [NUM_PORTS];
  port_t                owner_q [NUM_PORTS];
  port_t                owner_d [NUM_PORTS];
  port_t                last_q  [NUM_PORTS];
  port_t                last_d  [NUM_PORTS];

  logic [NUM_PORTS-1:0] grant_valid, xfer;
  port_t                grant_idx [NUM_PORTS];

  assign in_ack    = ready_q ? ~fifo_full : '0;
  assign fifo_push = in_enable & in_ack;
  assign dbg_out_state = state_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    noc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (flit_t)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push[i]),
      .data_i  (in_flit[i]),
      .pop_i   (fifo_pop[i]),
      .data_o  (head_flit[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  // Per-input request: a HEADER asks for its XY output while the input has
  // no active route; BODY/TAIL follow the latched route or are dropped.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      is_hdr[i]    = !fifo_empty[i] && (head_flit[i].flit_type == HEADER);
      hdr_route[i] = xy_route(32'(head_flit[i].payload[COORD_W-1:0]),
                              32'(head_flit[i].payload[2*COORD_W-1:COORD_W]),
                              X_COORD, Y_COORD);
      req_valid[i] = 1'b0;
      req_dest[i]  = route_q[i];
      drop[i]      = 1'b0;
      if (!fifo_empty[i]) begin
        if (is_hdr[i]) begin
          req_valid[i] = !route_valid_q[i];
          req_dest[i]  = hdr_route[i];
        end else begin
          req_valid[i] = route_valid_q[i];
          drop[i]      = !route_valid_q[i];
        end
      end
    end
  end

  // Output arbitration: IDLE searches from last winner + 1, LOCKED serves owner.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant_valid[o] = 1'b0;
      grant_idx[o]   = owner_q[o];
      if (state_q[o] == OUT_IDLE) begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          if (!grant_valid[o] && req_valid[rr_idx(last_q[o], k)] &&
              is_hdr[rr_idx(last_q[o], k)] &&
              req_dest[rr_idx(last_q[o], k)] == port_t'(o)) begin
            grant_valid[o] = 1'b1;
            grant_idx[o]   = rr_idx(last_q[o], k);
          end
        end
      end else if (req_valid[owner_q[o]] && !is_hdr[owner_q[o]] &&
                   req_dest[owner_q[o]] == port_t'(o)) begin
        grant_valid[o] = 1'b1;
      end
      out_enable[o] = grant_valid[o];
      out_flit[o]   = grant_valid[o] ? head_flit[grant_idx[o]] : '0;
      xfer[o]       = grant_valid[o] && out_ack[o];
    end
  end

  always_comb begin
    fifo_pop = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (xfer[o]) fifo_pop[grant_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    ready_d = 1'b1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      last_d[o]  = last_q[o];
      if (xfer[o]) begin
        if (state_q[o] == OUT_IDLE) begin
          state_d[o] = OUT_LOCKED;
          owner_d[o] = grant_idx[o];
          last_d[o]  = grant_idx[o];
        end else if (head_flit[grant_idx[o]].flit_type == TAIL) begin
          state_d[o] = OUT_IDLE;
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      route_valid_d[i] = route_valid_q[i];
      route_d[i]       = route_q[i];
      if (fifo_pop[i] && !drop[i]) begin
        if (is_hdr[i]) begin
          route_valid_d[i] = 1'b1;
          route_d[i]       = hdr_route[i];
        end else if (head_flit[i].flit_type == TAIL) begin
          route_valid_d[i] = 1'b0;
        end
      end
    end
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [31:0] count_q [NUM_PORTS];
  logic [31:0] count_d [NUM_PORTS];

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) count_d[o] = count_q[o] + 32'(xfer[o]);
  end

  assign flit_count = count_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      route_valid_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        route_q[p] <= LOCAL;
        state_q[p] <= OUT_IDLE;
        owner_q[p] <= NORTH;
        last_q[p]  <= LOCAL;
`ifdef NOC_ROUTER_STATS_EN
        count_q[p] <= '0;
`endif
      end
    end else begin
      ready_q       <= ready_d;
      route_valid_q <= route_valid_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        route_q[p] <= route_d[p];
        state_q[p] <= state_d[p];
        owner_q[p] <= owner_d[p];
        last_q[p]  <= last_d[p];
`ifdef NOC_ROUTER_STATS_EN
        count_q[p] <= count_d[p];
`endif
      end
    end
  end

endmodule

// File: tb/tb_noc_router.sv
// Directed bench for noc_router at (1,1): drivers push expected flits per
// output into queues, a negedge monitor pops and compares on every transfer.
module tb_noc_router;
  import noc_pkg::*;

  localparam int FW = $bits(flit_t);

  logic                 clk;
  logic                 rst_n;
  flit_t                in_flit  [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_enable, in_ack, out_enable, out_ack;
  flit_t                out_flit [NUM_PORTS];
  out_state_e           dbg_out_state [NUM_PORTS];
`ifdef NOC_ROUTER_STATS_EN
  logic [31:0]          flit_count [NUM_PORTS];
`endif

  logic [FW-1:0] exp_q [NUM_PORTS][$];
  int n_tests = 0;
  int n_fail  = 0;

  noc_router #(
    .X_COORD    (1),
    .Y_COORD    (1),
    .COORD_W    (4),
    .PAYLOAD_W  (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_flit       (in_flit),
    .in_enable     (in_enable),
    .in_ack        (in_ack),
    .out_flit      (out_flit),
    .out_enable    (out_enable),
    .out_ack       (out_ack),
`ifdef NOC_ROUTER_STATS_EN
    .flit_count    (flit_count),
`endif
    .dbg_out_state (dbg_out_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic flit_t pkt_flit(input int dx, input int dy, input int len,
                                     input logic [15:0] tag, input int k);
    flit_t     f;
    flit_hdr_t h;
    h.dst_addr.x  = NOC_COORD_W'(dx);
    h.dst_addr.y  = NOC_COORD_W'(dy);
    h.tail_length = 8'(len - 1);
    if (k == 0) begin
      f.flit_type = HEADER;
      f.payload   = {tag, h};
    end else begin
      f.flit_type = (k == len - 1) ? TAIL : BODY;
      f.payload   = {tag, 16'(k)};
    end
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input int p, input flit_t f);
    logic acc;
    int   n;
    n = 0;
    in_flit[p]   = f;
    in_enable[p] = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ack[p];
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout_p%0d: got no ack expected ack", p);
    end
    #1 in_enable[p] = 1'b0;
  endtask

  task automatic drive_pkt(input int p, input int dx, input int dy, input int len,
                           input logic [15:0] tag, input int n_send, input int chk_full_after);
    for (int k = 0; k < n_send; k++) begin
      send_flit(p, pkt_flit(dx, dy, len, tag, k));
      if (chk_full_after != 0 && k + 1 == chk_full_after) begin
        @(negedge clk);
        check($sformatf("in_ack_full_p%0d", p), 64'(in_ack[p]), 64'(0));
      end
    end
  endtask

  task automatic expect_pkt(input int o, input int dx, input int dy, input int len,
                            input logic [15:0] tag);
    for (int k = 0; k < len; k++) exp_q[o].push_back(FW'(pkt_flit(dx, dy, len, tag, k)));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (out_enable[o] && out_ack[o]) begin
          if (exp_q[o].size() == 0) begin
            check($sformatf("unexpected_out_%0d", o), 64'(out_flit[o]), 64'(0));
            if (64'(out_flit[o]) == 64'(0)) begin
              n_fail++;
              $display("FAIL unexpected_out_%0d: got zero flit expected none", o);
            end
          end else begin
            check($sformatf("out_flit_%0d", o), 64'(out_flit[o]), 64'(exp_q[o].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int both;
    flit_t f;
    rst_n     = 1'b0;
    in_enable = '0;
    out_ack   = '1;
    for (int i = 0; i < NUM_PORTS; i++) in_flit[i] = '0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int o = 0; o < NUM_PORTS; o++) begin
      check($sformatf("rst_out_enable_%0d", o), 64'(out_enable[o]), 64'(0));
      check($sformatf("rst_out_flit_%0d", o), 64'(out_flit[o]), 64'(0));
      check($sformatf("rst_in_ack_%0d", o), 64'(in_ack[o]), 64'(0));
    end
    #1 rst_n = 1'b1;
    #1 check("in_ack_before_edge", 64'(in_ack), 64'(0));
    @(negedge clk);
    check("in_ack_after_release", 64'(in_ack), 64'h1f);
    idle(1);

    // WEST -> (3,1) goes EAST, header visible one cycle after accept
    expect_pkt(EAST, 3, 1, 3, 16'hA001);
    fork
      drive_pkt(WEST, 3, 1, 3, 16'hA001, 3, 0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(in_enable[WEST] && in_ack[WEST]) && n < 20);
        @(negedge clk);
        check("lat_east_enable", 64'(out_enable[EAST]), 64'(1));
        check("lat_east_hdr", 64'(out_flit[EAST]), 64'(pkt_flit(3, 1, 3, 16'hA001, 0)));
        check("lat_east_state_idle", 64'(dbg_out_state[EAST]), 64'(OUT_IDLE));
        @(negedge clk);
        check("east_locked", 64'(dbg_out_state[EAST]), 64'(OUT_LOCKED));
      end
    join
    idle(3);
    check("east_idle_after_tail", 64'(dbg_out_state[EAST]), 64'(OUT_IDLE));
`ifdef NOC_ROUTER_STATS_EN
    for (int o = 0; o < NUM_PORTS; o++)
      check($sformatf("flit_count_%0d", o), 64'(flit_count[o]), (o == EAST) ? 64'(3) : 64'(0));
`endif

    // Orphan TAIL is dropped, then a normal packet to LOCAL still works
    f.flit_type = TAIL;
    f.payload   = 32'hDEAD_0001;
    send_flit(WEST, f);
    @(negedge clk);
    check("drop_no_out", 64'(out_enable), 64'(0));
    idle(2);
    expect_pkt(LOCAL, 1, 1, 2, 16'hB002);
    drive_pkt(WEST, 1, 1, 2, 16'hB002, 2, 0);
    idle(3);

    // NORTH and SOUTH both to LOCAL: NORTH first, SOUTH fills and stalls
    expect_pkt(LOCAL, 1, 1, 5, 16'hC003);
    expect_pkt(LOCAL, 1, 1, 5, 16'hC004);
    fork
      drive_pkt(NORTH, 1, 1, 5, 16'hC003, 5, 0);
      drive_pkt(SOUTH, 1, 1, 5, 16'hC004, 5, 4);
    join
    idle(8);

    // Backpressure on EAST while WEST sends 6 flits
    out_ack[EAST] = 1'b0;
    expect_pkt(EAST, 3, 1, 6, 16'hD005);
    fork
      drive_pkt(WEST, 3, 1, 6, 16'hD005, 6, 4);
      begin
        repeat (10) @(posedge clk);
        #1 out_ack[EAST] = 1'b1;
      end
    join
    idle(8);

    // Independent concurrent streams WEST->EAST and NORTH->SOUTH
    expect_pkt(EAST, 2, 1, 5, 16'hE006);
    expect_pkt(SOUTH, 1, 3, 5, 16'hE007);
    both = 0;
    fork
      drive_pkt(WEST, 2, 1, 5, 16'hE006, 5, 0);
      drive_pkt(NORTH, 1, 3, 5, 16'hE007, 5, 0);
      repeat (8) begin
        @(negedge clk);
        if (out_enable[EAST] && out_enable[SOUTH]) both++;
      end
    join
    check("concurrent_cycles", 64'(both), 64'(5));
    idle(4);

    // Reset mid-packet discards the partial packet
    out_ack[EAST] = 1'b0;
    drive_pkt(WEST, 3, 1, 4, 16'hF008, 2, 0);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n   = 1'b1;
    out_ack = '1;
    idle(5);
    @(negedge clk);
    check("midrst_no_out", 64'(out_enable), 64'(0));
    check("midrst_east_idle", 64'(dbg_out_state[EAST]), 64'(OUT_IDLE));
    check("midrst_in_ack", 64'(in_ack), 64'h1f);
    idle(1);
    expect_pkt(EAST, 3, 1, 3, 16'hF009);
    drive_pkt(WEST, 3, 1, 3, 16'hF009, 3, 0);
    idle(10);

    for (int o = 0; o < NUM_PORTS; o++)
      check($sformatf("drain_%0d", o), 64'(exp_q[o].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
